line_burst_adaptor: RTL and testbench
=====================================

// Module: line_burst_adaptor
// PURPOSE
//  Initiator-side partner of the cache data array: moves whole cache lines between the
//  cache controller (one s_line-bit line per request) and main memory (n_beats x s_burst
//  bursts). Fills deserialize memory beats into a line for the data array; writebacks
//  serialize a dirty line out. Sits between cache control/data array and the memory port.
// PARAMETERS
//  s_offset  5              byte-offset bits of a line; address_o low s_offset bits forced 0
//  s_line    8*2**s_offset  line width in bits (256)
//  s_burst   64             memory beat width in bits
//  n_beats   s_line/s_burst beats per line (4); must be a power of 2, >=2
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  address_i   in   32       line address from cache
//  read_i      in   1        fill request (level, sampled only in IDLE)
//  write_i     in   1        writeback request (level, sampled only in IDLE)
//  line_i      in   s_line   line to write back, captured with write_i
//  line_o      out  s_line   assembled fill line
//  resp_o      out  1        one-cycle completion pulse (fill or writeback)
//  address_o   out  32       aligned line address to memory
//  read_o      out  1        memory read burst request
//  write_o     out  1        memory write burst request
//  burst_o     out  s_burst  current write beat
//  burst_i     in   s_burst  current read beat
//  resp_i      in   1        memory beat handshake (one beat per asserted cycle)
// BEHAVIOUR
//  - Reset: state IDLE; line_o, address_o, burst_o, beat counter = 0; read_o, write_o, resp_o = 0.
//  - FSM: IDLE -> RD_BURST | WR_BURST -> DONE -> IDLE.
//  - IDLE: write_i has priority over read_i when both are high. On accept, latch
//    {address_i[31:s_offset], s_offset'b0} into address_o and (write) line_i into a shift
//    buffer; beat counter = 0. The next cycle drives read_o/write_o = 1.
//  - RD_BURST: read_o=1. Each cycle with resp_i=1 stores burst_i into line_o
//    [s_burst*cnt +: s_burst] (beat 0 = least-significant) and increments cnt. Gaps with
//    resp_i=0 are allowed; no timeout. After beat n_beats-1: read_o=0 next cycle, go DONE.
//  - WR_BURST: write_o=1; burst_o = line beat cnt. Advance on resp_i=1; after the last beat
//    write_o=0, go DONE.
//  - DONE: resp_o=1 for exactly one cycle, then IDLE. line_o is stable from this cycle
//    until the next fill's first beat. Min latency, request to resp_o = n_beats+2 cycles.
//  - read_i/write_i/address_i/line_i changes while busy are ignored. The caller drops
//    read_i/write_i on resp_o; a request still high in IDLE after DONE starts a new transfer.
//  - resp_i while IDLE or DONE is ignored (no counter change).
//  - Counter is log2(n_beats) bits; wrap-around is never relied on (exit at the last beat).
//  - rst mid-burst: immediate abort to the reset state; no resp_o; partial line_o is cleared.
// CONFIGURATION
//  ADAPTOR_STATS_EN defined: adds outputs fill_cnt_o[31:0] and wb_cnt_o[31:0], reset 0,
//   each incremented in DONE for its transfer type, saturating at 32'hFFFF_FFFF.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 fill: read_i, address_i=32'h0000_1234; beats 64'h1..64'h4 back-to-back -> address_o
//    =32'h0000_1220, read_o high 4 cycles, line_o={4,3,2,1}, resp_o single pulse.
//  2 writeback: write_i, line_i={64'hD,64'hC,64'hB,64'hA}, resp_i every other cycle ->
//    burst_o A,B,C,D in order, each held until resp_i, write_o drops after D, one resp_o.
//  3 read_i and write_i together -> write burst first; read is accepted only after resp_o
//    if read_i is still high.
//  4 rst asserted after beat 2 of a fill -> next cycle read_o=0, line_o=0, no resp_o; a
//    fresh fill then completes normally.
//  5 stray resp_i in IDLE, address_i changes mid-burst -> no state/counter change,
//    address_o unchanged.
//  6 ADAPTOR_STATS_EN: 3 fills and 2 writebacks -> fill_cnt_o=3, wb_cnt_o=2; rst -> both 0.

Source files
------------

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: moves whole cache lines between the cache and an n_beats x s_burst memory port.
// Latency: resp_o follows the accepting cycle by n_beats+1 cycles when a beat arrives every cycle.
// Backpressure: each beat waits for resp_i. The optional ADAPTOR_STATS_EN adds fill_cnt_o/wb_cnt_o.
module line_burst_adaptor #(
    parameter int s_offset = 5,
    parameter int s_line   = 8 * 2**s_offset,
    parameter int s_burst  = 64,
    parameter int n_beats  = s_line / s_burst
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    output logic               resp_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [s_burst-1:0] burst_o,
    input  logic [s_burst-1:0] burst_i,
    input  logic               resp_i
`ifdef ADAPTOR_STATS_EN
    ,
    output logic [31:0]        fill_cnt_o,
    output logic [31:0]        wb_cnt_o
`endif
);

    localparam int          CW        = $clog2(n_beats);
    localparam logic [CW-1:0] LAST_BEAT = CW'(n_beats - 1);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [s_line-1:0]   wr_buf;
`ifdef ADAPTOR_STATS_EN
    logic                is_wr;
`endif

    // The writeback line is shifted down one beat per handshake, so beat cnt is always at the bottom.
    assign burst_o = wr_buf[s_burst-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            line_o    <= '0;
            address_o <= '0;
            wr_buf    <= '0;
`ifdef ADAPTOR_STATS_EN
            is_wr      <= 1'b0;
            fill_cnt_o <= '0;
            wb_cnt_o   <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (write_i || read_i) begin
                        address_o <= address_i & ADDR_MASK;
                        cnt       <= '0;
                        if (write_i) wr_buf <= line_i;
`ifdef ADAPTOR_STATS_EN
                        is_wr <= write_i;
`endif
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_o[int'(cnt) * s_burst +: s_burst] <= burst_i;
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        wr_buf <= wr_buf >> s_burst;
                        cnt    <= cnt + 1'b1;
                    end
                end
                DONE: begin
`ifdef ADAPTOR_STATS_EN
                    if (is_wr) begin
                        if (wb_cnt_o != 32'hFFFF_FFFF) wb_cnt_o <= wb_cnt_o + 32'd1;
                    end else begin
                        if (fill_cnt_o != 32'hFFFF_FFFF) fill_cnt_o <= fill_cnt_o + 32'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        case (state)
            IDLE: begin
                if (write_i)     state_nxt = WR_BURST;
                else if (read_i) state_nxt = RD_BURST;
            end
            RD_BURST: begin
                read_o = 1'b1;
                if (resp_i && cnt == LAST_BEAT) state_nxt = DONE;
            end
            WR_BURST: begin
                write_o = 1'b1;
                if (resp_i && cnt == LAST_BEAT) state_nxt = DONE;
            end
            DONE: begin
                resp_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: directed scenarios plus randomized fills/writebacks
// against a line/beat reference model.
module tb_line_burst_adaptor;

    localparam int S_OFF   = 5;
    localparam int S_LINE  = 256;
    localparam int S_BURST = 64;
    localparam int N_BEATS = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic [S_LINE-1:0]  line_i;
    logic [S_LINE-1:0]  line_o;
    logic               resp_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;
    logic [S_BURST-1:0] burst_o;
    logic [S_BURST-1:0] burst_i;
    logic               resp_i;
`ifdef ADAPTOR_STATS_EN
    logic [31:0]        fill_cnt_o;
    logic [31:0]        wb_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [S_LINE-1:0] last_line;
    logic [31:0]       last_addr;

    always #5 clk = ~clk;

    line_burst_adaptor dut (
        .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i),
        .resp_i(resp_i)
`ifdef ADAPTOR_STATS_EN
        , .fill_cnt_o(fill_cnt_o), .wb_cnt_o(wb_cnt_o)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return a - (a % (32'd1 << S_OFF));
    endfunction

    function automatic logic [S_BURST-1:0] beat_of(input logic [S_LINE-1:0] l, input int i);
        logic [S_LINE-1:0] sh;
        sh = l >> (S_BURST * i);
        return sh[S_BURST-1:0];
    endfunction

    task automatic do_fill(input logic [31:0] addr, input int max_gap, input bit scramble);
        logic [S_BURST-1:0] beats [N_BEATS];
        logic [S_LINE-1:0]  exp_line;
        int gap;
        exp_line = '0;
        for (int i = 0; i < N_BEATS; i++) begin
            beats[i] = {$urandom, $urandom};
            exp_line = exp_line | (S_LINE'(beats[i]) << (S_BURST * i));
        end
        read_i = 1'b1; write_i = 1'b0; address_i = addr;
        tick;
        for (int i = 0; i < N_BEATS; i++) begin
            gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            for (int g = 0; g < gap; g++) begin
                checks++; if (read_o !== 1'b1) begin errors++; $display("FAIL fill_gap_read_o got=%b exp=1", read_o); end
                resp_i = 1'b0; burst_i = {$urandom, $urandom};
                if (scramble) begin address_i = $urandom; line_i = {8{$urandom}}; end
                tick;
            end
            checks++; if (read_o !== 1'b1) begin errors++; $display("FAIL fill_read_o beat%0d got=%b exp=1", i, read_o); end
            checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL fill_early_resp beat%0d got=%b exp=0", i, resp_o); end
            resp_i = 1'b1; burst_i = beats[i];
            if (scramble) address_i = $urandom;
            tick;
        end
        resp_i = 1'b0; burst_i = '0;
        checks++; if (read_o !== 1'b0) begin errors++; $display("FAIL fill_read_o_drop got=%b exp=0", read_o); end
        checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL fill_resp got=%b exp=1", resp_o); end
        checks++; if (line_o !== exp_line) begin errors++; $display("FAIL fill_line got=%h exp=%h", line_o, exp_line); end
        checks++; if (address_o !== align(addr)) begin errors++; $display("FAIL fill_addr got=%h exp=%h", address_o, align(addr)); end
        read_i = 1'b0;
        tick;
        checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL fill_resp_pulse got=%b exp=0", resp_o); end
        checks++; if (line_o !== exp_line) begin errors++; $display("FAIL fill_line_hold got=%h exp=%h", line_o, exp_line); end
        last_line = exp_line;
        last_addr = align(addr);
    endtask

    task automatic do_wb(input logic [31:0] addr, input logic [S_LINE-1:0] l, input int max_gap, input bit scramble);
        int gap;
        write_i = 1'b1; read_i = 1'b0; line_i = l; address_i = addr;
        tick;
        for (int i = 0; i < N_BEATS; i++) begin
            gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            for (int g = 0; g < gap; g++) begin
                checks++; if (burst_o !== beat_of(l, i)) begin errors++; $display("FAIL wb_gap_burst beat%0d got=%h exp=%h", i, burst_o, beat_of(l, i)); end
                resp_i = 1'b0;
                if (scramble) begin address_i = $urandom; line_i = {8{$urandom}}; end
                tick;
            end
            checks++; if (write_o !== 1'b1) begin errors++; $display("FAIL wb_write_o beat%0d got=%b exp=1", i, write_o); end
            checks++; if (burst_o !== beat_of(l, i)) begin errors++; $display("FAIL wb_burst beat%0d got=%h exp=%h", i, burst_o, beat_of(l, i)); end
            resp_i = 1'b1;
            tick;
        end
        resp_i = 1'b0;
        checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL wb_write_o_drop got=%b exp=0", write_o); end
        checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL wb_resp got=%b exp=1", resp_o); end
        checks++; if (address_o !== align(addr)) begin errors++; $display("FAIL wb_addr got=%h exp=%h", address_o, align(addr)); end
        write_i = 1'b0;
        tick;
        checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL wb_resp_pulse got=%b exp=0", resp_o); end
        last_addr = align(addr);
    endtask

    task automatic test_reset;
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = 32'hFFFF_FFFF; line_i = '1; burst_i = '1;
        tick; tick;
        checks++; if (line_o !== '0) begin errors++; $display("FAIL reset_line got=%h exp=0", line_o); end
        checks++; if (address_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", address_o); end
        checks++; if (burst_o !== '0) begin errors++; $display("FAIL reset_burst got=%h exp=0", burst_o); end
        checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b exp=000", {read_o, write_o, resp_o}); end
        rst = 1'b0;
        tick;
        last_line = '0; last_addr = '0;
    endtask

    task automatic test_fill;
        do_fill(32'h0000_1234, 0, 1'b0);
    endtask

    task automatic test_writeback;
        logic [S_LINE-1:0] l;
        l = {64'hD, 64'hC, 64'hB, 64'hA};
        do_wb(32'h0000_5678, l, 1, 1'b0);
    endtask

    task automatic test_both_requests;
        logic [S_LINE-1:0] l;
        logic [S_LINE-1:0] exp_line;
        logic [S_BURST-1:0] b;
        l = {8{$urandom}};
        read_i = 1'b1; write_i = 1'b1; line_i = l; address_i = 32'hABCD_EF77;
        tick;
        checks++; if ({write_o, read_o} !== 2'b10) begin errors++; $display("FAIL both_prio got=%b exp=10", {write_o, read_o}); end
        for (int i = 0; i < N_BEATS; i++) begin
            checks++; if (burst_o !== beat_of(l, i)) begin errors++; $display("FAIL both_burst beat%0d got=%h exp=%h", i, burst_o, beat_of(l, i)); end
            resp_i = 1'b1; tick;
        end
        resp_i = 1'b0;
        checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL both_wb_resp got=%b exp=1", resp_o); end
        write_i = 1'b0;
        tick;
        checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin errors++; $display("FAIL both_idle got=%b exp=000", {read_o, write_o, resp_o}); end
        tick;
        checks++; if (read_o !== 1'b1) begin errors++; $display("FAIL both_read_after got=%b exp=1", read_o); end
        exp_line = '0;
        for (int i = 0; i < N_BEATS; i++) begin
            b = {$urandom, $urandom};
            exp_line = exp_line | (S_LINE'(b) << (S_BURST * i));
            resp_i = 1'b1; burst_i = b; tick;
        end
        resp_i = 1'b0;
        checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL both_rd_resp got=%b exp=1", resp_o); end
        checks++; if (line_o !== exp_line) begin errors++; $display("FAIL both_rd_line got=%h exp=%h", line_o, exp_line); end
        read_i = 1'b0;
        tick;
        last_line = exp_line; last_addr = align(32'hABCD_EF77);
    endtask

    task automatic test_reset_mid_fill;
        read_i = 1'b1; write_i = 1'b0; address_i = 32'h0000_9999;
        tick;
        for (int i = 0; i < 2; i++) begin
            resp_i = 1'b1; burst_i = {$urandom, $urandom}; tick;
        end
        resp_i = 1'b0; read_i = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (read_o !== 1'b0) begin errors++; $display("FAIL abort_read_o got=%b exp=0", read_o); end
        checks++; if (line_o !== '0) begin errors++; $display("FAIL abort_line got=%h exp=0", line_o); end
        checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL abort_resp got=%b exp=0", resp_o); end
        tick;
        checks++; if ({read_o, resp_o} !== 2'b00) begin errors++; $display("FAIL abort_after got=%b exp=00", {read_o, resp_o}); end
        last_line = '0; last_addr = '0;
        do_fill(32'h0000_4444, 0, 1'b0);
    endtask

    task automatic test_stray_resp;
        for (int i = 0; i < 3; i++) begin
            resp_i = 1'b1; burst_i = {$urandom, $urandom}; tick;
            checks++; if ({read_o, write_o, resp_o} !== 3'b000) begin errors++; $display("FAIL stray_ctrl got=%b exp=000", {read_o, write_o, resp_o}); end
            checks++; if (line_o !== last_line) begin errors++; $display("FAIL stray_line got=%h exp=%h", line_o, last_line); end
            checks++; if (address_o !== last_addr) begin errors++; $display("FAIL stray_addr got=%h exp=%h", address_o, last_addr); end
        end
        resp_i = 1'b0;
        do_fill(32'h1357_9BDF, 2, 1'b1);
        do_wb(32'h2468_ACE0, {8{$urandom}}, 2, 1'b1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(1, 0) == 0) do_fill($urandom, 3, 1'($urandom_range(1, 0)));
            else do_wb($urandom, {8{$urandom}}, 3, 1'($urandom_range(1, 0)));
        end
    endtask

`ifdef ADAPTOR_STATS_EN
    task automatic test_stats;
        rst = 1'b1; tick; rst = 1'b0; tick;
        for (int i = 0; i < 3; i++) do_fill($urandom, 1, 1'b0);
        for (int i = 0; i < 2; i++) do_wb($urandom, {8{$urandom}}, 1, 1'b0);
        checks++; if (fill_cnt_o !== 32'd3) begin errors++; $display("FAIL stats_fill got=%0d exp=3", fill_cnt_o); end
        checks++; if (wb_cnt_o !== 32'd2) begin errors++; $display("FAIL stats_wb got=%0d exp=2", wb_cnt_o); end
        rst = 1'b1; tick; rst = 1'b0;
        checks++; if ({fill_cnt_o, wb_cnt_o} !== 64'd0) begin errors++; $display("FAIL stats_reset got=%h exp=0", {fill_cnt_o, wb_cnt_o}); end
    endtask
`endif

    initial begin
        test_reset;
        test_fill;
        test_writeback;
        test_both_requests;
        test_reset_mid_fill;
        test_stray_resp;
        test_random;
`ifdef ADAPTOR_STATS_EN
        test_stats;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
